// File: rtl/x86_pkg.sv
// x86_pkg: definitions shared by the front end of the tiny x86 core.
//   - PFX_*      : segment-override prefix opcodes
//   - seg_t      : segment codes, the same encoding the register stage uses
//   - INSTR_W    : width of the instruction window handed to the register stage
//   - bus_state_t: fetch-side request state
//   - is_seg_prefix / prefix_segment: prefix recognition and decode helpers
package x86_pkg;

    localparam int INSTR_W = 48;

    localparam logic [7:0] PFX_ES = 8'h26;
    localparam logic [7:0] PFX_CS = 8'h2E;
    localparam logic [7:0] PFX_SS = 8'h36;
    localparam logic [7:0] PFX_DS = 8'h3E;

    typedef enum logic [1:0] {
        SEG_ES = 2'b00,
        SEG_CS = 2'b01,
        SEG_SS = 2'b10,
        SEG_DS = 2'b11
    } seg_t;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_REQ  = 1'b1
    } bus_state_t;

    function automatic logic is_seg_prefix(input logic [7:0] b);
        return (b == PFX_ES) || (b == PFX_CS) || (b == PFX_SS) || (b == PFX_DS);
    endfunction

    // All four override opcodes are 001s_s110; bits [4:3] are the segment code.
    function automatic seg_t prefix_segment(input logic [7:0] b);
        return seg_t'(b[4:3]);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH x 8 circular byte buffer with single-byte push, multi-byte
// pop and a WIN-byte read window starting at the head.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   clear            : drop all contents (takes priority over push/pop)
//   push, push_data  : append one byte at the tail
//   pop_len          : number of bytes to drop from the head this cycle
//   count            : bytes currently held (0..DEPTH)
//   head_byte        : byte at the head
//   window           : WIN bytes from the head, byte k at [8k+7:8k], wrapping mod DEPTH
module byte_fifo
    import x86_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIN   = 6
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic [$clog2(DEPTH):0]   pop_len,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               head_byte,
    output logic [8*WIN-1:0]         window
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    // With count == DEPTH the tail aliases the head; a push is then only legal
    // together with a pop, which frees exactly the slot being written.
    assign tail = head + count[AW-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            head  <= head + pop_len[AW-1:0];
            count <= count - pop_len + CW'(push);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !clear) begin
            mem[tail] <= push_data;
        end
    end

    assign head_byte = mem[head];

    always_comb begin
        window = '0;
        for (int k = 0; k < WIN; k++) window[8*k +: 8] = mem[head + AW'(k)];
    end

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch stage. Fetches code bytes from CS:IP
// over a byte-wide bus into a circular queue, strips segment-override
// prefixes and presents a WIN-byte window to the register stage.
// Ports:
//   clock, reset_n            : clock, asynchronous active-low reset
//   bus_req/bus_addr          : fetch request and 20-bit physical address
//   bus_ack/bus_data          : byte returned, ends the request
//   flush, new_cs, new_ip     : control transfer, restart fetch at new_cs:new_ip
//   consume, consume_len      : decoder retires consume_len (1..WIN) bytes
//   instr, instr_valid        : window (byte 0 = opcode) and its validity
//   segpref, segment          : active override for the current instruction
//   bitsel, direct            : opcode w and d bits
//   cs, ip                    : code segment and offset of window byte 0
module prefetch_queue
    import x86_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIN   = INSTR_W / 8
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               bus_req,
    output logic [19:0]        bus_addr,
    input  logic               bus_ack,
    input  logic [7:0]         bus_data,
    input  logic               flush,
    input  logic [15:0]        new_cs,
    input  logic [15:0]        new_ip,
    input  logic               consume,
    input  logic [2:0]         consume_len,
    output logic [8*WIN-1:0]   instr,
    output logic               instr_valid,
    output logic               segpref,
    output logic [1:0]         segment,
    output logic               bitsel,
    output logic               direct,
    output logic [15:0]        cs,
    output logic [15:0]        ip
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic [CW-1:0] pop_len;
    logic [CW-1:0] avail;
    logic [CW-1:0] count_next;
    logic [7:0]    head_byte;
    logic          head_is_pfx;
    logic          len_ok;
    logic          take;
    logic          strip;
    logic          accept;
    logic [15:0]   fetch_ip;
    seg_t          seg_q;
    bus_state_t    state;
    bus_state_t    state_next;

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIN   (WIN)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (accept),
        .push_data (bus_data),
        .pop_len   (pop_len),
        .count     (count),
        .head_byte (head_byte),
        .window    (instr)
    );

    // Queue-side decisions
    assign head_is_pfx = (count != '0) && is_seg_prefix(head_byte);
    assign instr_valid = (count >= CW'(WIN)) && !is_seg_prefix(head_byte);
    assign len_ok      = (consume_len != 3'd0) && (int'(consume_len) <= WIN);
    assign take        = consume && instr_valid && len_ok;
    // A prefix is only peeled off when the decoder is not trying to retire
    // anything; the window cannot be valid while a prefix heads it anyway.
    assign strip       = head_is_pfx && !consume && !flush;

    always_comb begin
        pop_len = '0;
        if (flush)      pop_len = '0;
        else if (take)  pop_len = CW'(consume_len);
        else if (strip) pop_len = CW'(1);
    end

    assign avail      = count - pop_len;
    // The request gate keeps a slot free for the outstanding byte; the extra
    // room test only protects against an ack nobody asked for.
    assign accept     = bus_ack && !flush && (avail < CW'(DEPTH));
    assign count_next = flush ? '0 : avail + CW'(accept);

    // Bus request state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= BUS_IDLE;
        else          state <= state_next;
    end

    // A flush always passes through IDLE for one cycle, so an abandoned
    // request is visibly dropped before the new address is issued.
    always_comb begin
        state_next = state;
        bus_req    = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (!flush && (count_next < CW'(DEPTH))) state_next = BUS_REQ;
            end
            BUS_REQ: begin
                bus_req = 1'b1;
                if (flush || (accept && (count_next >= CW'(DEPTH)))) state_next = BUS_IDLE;
            end
            default: state_next = BUS_IDLE;
        endcase
    end

    assign bus_addr = {cs, 4'h0} + {4'h0, fetch_ip};

    // Architectural pointers and prefix state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs       <= '0;
            ip       <= '0;
            fetch_ip <= '0;
            segpref  <= 1'b0;
            seg_q    <= SEG_ES;
        end else if (flush) begin
            cs       <= new_cs;
            ip       <= new_ip;
            fetch_ip <= new_ip;
            segpref  <= 1'b0;
            seg_q    <= SEG_ES;
        end else begin
            if (accept) fetch_ip <= fetch_ip + 16'd1;
            if (take) begin
                ip      <= ip + {13'd0, consume_len};
                segpref <= 1'b0;
                seg_q   <= SEG_ES;
            end else if (strip) begin
                // Repeated prefixes simply overwrite: the last one wins.
                ip      <= ip + 16'd1;
                segpref <= 1'b1;
                seg_q   <= prefix_segment(head_byte);
            end
        end
    end

    assign segment = seg_q;
    assign bitsel  = instr[0];
    assign direct  = instr[1];

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        bus_req;
    logic [19:0] bus_addr;
    logic        bus_ack;
    logic [7:0]  bus_data;
    logic        flush;
    logic [15:0] new_cs;
    logic [15:0] new_ip;
    logic        consume;
    logic [2:0]  consume_len;
    logic [47:0] instr;
    logic        instr_valid;
    logic        segpref;
    logic [1:0]  segment;
    logic        bitsel;
    logic        direct;
    logic [15:0] cs;
    logic [15:0] ip;

    prefetch_queue #(.DEPTH(DEPTH), .WIN(6)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_ack     (bus_ack),
        .bus_data    (bus_data),
        .flush       (flush),
        .new_cs      (new_cs),
        .new_ip      (new_ip),
        .consume     (consume),
        .consume_len (consume_len),
        .instr       (instr),
        .instr_valid (instr_valid),
        .segpref     (segpref),
        .segment     (segment),
        .bitsel      (bitsel),
        .direct      (direct),
        .cs          (cs),
        .ip          (ip)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: code memory, byte queue and architectural registers.
    logic [7:0]  code_mem [int];
    logic [7:0]  mq [$];
    logic [15:0] m_cs, m_ip, m_fip;
    logic        m_segpref;
    logic [1:0]  m_seg;
    bit          m_pend, prev_req, last_acked;
    logic [19:0] last_addr;

    function automatic bit is_pfx(input logic [7:0] b);
        return b inside {8'h26, 8'h2E, 8'h36, 8'h3E};
    endfunction

    function automatic logic [7:0] code_byte(input logic [19:0] a);
        logic [7:0] b;
        if (!code_mem.exists(int'(a))) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0: b = 8'h26;
                    1: b = 8'h2E;
                    2: b = 8'h36;
                    default: b = 8'h3E;
                endcase
            end else begin
                b = 8'($urandom);
            end
            code_mem[int'(a)] = b;
        end
        return code_mem[int'(a)];
    endfunction

    function automatic bit m_valid();
        return (mq.size() >= 6) && !is_pfx(mq[0]);
    endfunction

    function automatic logic [47:0] m_window();
        logic [47:0] w;
        w = '0;
        for (int k = 0; k < 6 && k < mq.size(); k++) w[8*k +: 8] = mq[k];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [19:0] a, input logic [7:0] b);
        code_mem[int'(a)] = b;
    endtask

    task automatic model_reset();
        mq.delete();
        m_cs = '0; m_ip = '0; m_fip = '0;
        m_segpref = 1'b0; m_seg = 2'b00;
        m_pend = 1'b0; prev_req = 1'b0; last_acked = 1'b0;
    endtask

    task automatic check_outputs();
        logic [19:0] ea;
        bit v;
        ea = {m_cs, 4'h0} + {4'h0, m_fip};
        v  = m_valid();
        chk("bus_req", bus_req, m_pend);
        if (m_pend) chk("bus_addr", bus_addr, ea);
        chk("instr_valid", instr_valid, v);
        if (v) begin
            chk("instr", instr, m_window());
            chk("bitsel", bitsel, mq[0][0]);
            chk("direct", direct, mq[0][1]);
        end
        chk("ip", ip, m_ip);
        chk("cs", cs, m_cs);
        chk("segpref", segpref, m_segpref);
        if (m_segpref) chk("segment", segment, m_seg);
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    // Entered and left at 1 time unit after a rising edge.
    task automatic step(input bit fl, input logic [15:0] ncs, input logic [15:0] nip,
                        input bit cons, input logic [2:0] len, input bit ack_en);
        logic [19:0] a;
        bit ack;
        a   = {m_cs, 4'h0} + {4'h0, m_fip};
        ack = ack_en && m_pend && prev_req;
        flush = fl; new_cs = ncs; new_ip = nip;
        consume = cons; consume_len = len;
        bus_ack  = ack;
        bus_data = ack ? code_byte(a) : 8'($urandom);
        #1;
        check_outputs();
        prev_req   = m_pend;
        last_acked = ack && !fl;
        last_addr  = a;
        if (fl) begin
            mq.delete();
            m_cs = ncs; m_ip = nip; m_fip = nip;
            m_segpref = 1'b0; m_seg = 2'b00;
            m_pend = 1'b0;
        end else begin
            if (cons && m_valid() && len >= 3'd1 && len <= 3'd6) begin
                repeat (len) void'(mq.pop_front());
                m_ip += 16'(len);
                m_segpref = 1'b0; m_seg = 2'b00;
            end else if (!cons && mq.size() > 0 && is_pfx(mq[0])) begin
                m_seg = mq[0][4:3];
                void'(mq.pop_front());
                m_ip += 16'd1;
                m_segpref = 1'b1;
            end
            if (ack) begin
                mq.push_back(bus_data);
                m_fip += 16'd1;
            end
            m_pend = (mq.size() < DEPTH);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          n_ack;
        int          guard;
        logic [19:0] seen [8];
        logic [19:0] exp_wrap [6];
        bit          r_fl, r_cons, r_ack;
        logic [15:0] r_cs, r_ip;
        logic [2:0]  r_len;

        exp_wrap = '{20'h0FFFE, 20'h0FFFF, 20'h00000, 20'h00001, 20'h00002, 20'h00003};

        flush = 0; new_cs = 0; new_ip = 0; consume = 0; consume_len = 0;
        bus_ack = 0; bus_data = 0; reset_n = 0;
        model_reset();

        // Reset state
        #3;
        check_outputs();
        chk("rst_instr", instr, 48'h0);
        chk("rst_bus_addr", bus_addr, 20'h0);
        chk("rst_segment", segment, 2'b00);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1;
        step(0, 0, 0, 0, 0, 0);
        chk("boot_req", bus_req, 1'b1);
        chk("boot_addr", bus_addr, 20'h00000);

        // Flush to 1000:0100 and fetch six bytes with zero-wait acks
        poke(20'h10100, 8'h88); poke(20'h10101, 8'hC3);
        for (int k = 2; k < 8; k++) poke(20'h10100 + 20'(k), 8'h90);
        step(1, 16'h1000, 16'h0100, 0, 0, 0);
        n_ack = 0; guard = 0;
        while (n_ack < 6 && guard < 50) begin
            step(0, 0, 0, (n_ack == 2), 3'd3, 1);
            if (last_acked) begin seen[n_ack] = last_addr; n_ack++; end
            guard++;
        end
        chk("fetch6_done", n_ack, 6);
        for (int k = 0; k < 6; k++) chk("fetch6_addr", seen[k], 20'h10100 + 20'(k));
        chk("win_valid", instr_valid, 1'b1);
        chk("win_instr", instr, 48'h9090_9090_C388);
        chk("win_bitsel", bitsel, 1'b0);
        chk("win_direct", direct, 1'b0);
        chk("win_ip", ip, 16'h0100);
        step(0, 0, 0, 1, 3'd6, 0);

        // CS override prefix ahead of 01 D8
        poke(20'h10100, 8'h2E); poke(20'h10101, 8'h01); poke(20'h10102, 8'hD8);
        for (int k = 3; k < 16; k++) poke(20'h10100 + 20'(k), 8'h90);
        step(1, 16'h1000, 16'h0100, 0, 0, 0);
        n_ack = 0; guard = 0;
        while (n_ack < 7 && guard < 50) begin
            step(0, 0, 0, 0, 0, 1);
            if (last_acked) n_ack++;
            guard++;
        end
        chk("pfx_fetch_done", n_ack, 7);
        chk("pfx_valid", instr_valid, 1'b1);
        chk("pfx_segpref", segpref, 1'b1);
        chk("pfx_segment", segment, 2'b01);
        chk("pfx_ip", ip, 16'h0101);
        chk("pfx_bitsel", bitsel, 1'b1);
        chk("pfx_opcode", instr[7:0], 8'h01);
        step(0, 0, 0, 1, 3'd2, 0);
        chk("pfx_clr_segpref", segpref, 1'b0);
        chk("pfx_clr_ip", ip, 16'h0103);

        // Queue nearly full: consume and ack together, then fill and drain
        guard = 0;
        while (mq.size() < 7 && guard < 30) begin step(0, 0, 0, 0, 0, 1); guard++; end
        chk("fill7", mq.size(), 7);
        step(0, 0, 0, 1, 3'd3, 1);
        chk("pushpop_acked", last_acked, 1'b1);
        chk("pushpop_req", bus_req, 1'b1);
        guard = 0;
        while (mq.size() < 8 && guard < 30) begin step(0, 0, 0, 0, 0, 1); guard++; end
        chk("fill8", mq.size(), 8);
        chk("full_req_low", bus_req, 1'b0);
        step(0, 0, 0, 1, 3'd3, 0);
        chk("refill_req", bus_req, 1'b1);

        // Flush with an ack in the same cycle
        step(0, 0, 0, 0, 0, 0);
        step(1, 16'h2000, 16'h0200, 0, 0, 1);
        chk("flush_ack_seen", last_addr != 20'h0, 1'b1);
        chk("flush_gap_req", bus_req, 1'b0);
        chk("flush_gap_valid", instr_valid, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        chk("flush_reissue_req", bus_req, 1'b1);
        chk("flush_reissue_addr", bus_addr, 20'h20200);
        chk("flush_cs", cs, 16'h2000);

        // Offset wrap FFFE -> 0000 with cs = 0
        for (int k = 0; k < 8; k++) poke(20'(16'hFFFE + 16'(k)), 8'h90);
        step(1, 16'h0000, 16'hFFFE, 0, 0, 0);
        n_ack = 0; guard = 0;
        while (n_ack < 6 && guard < 50) begin
            step(0, 0, 0, 0, 0, 1);
            if (last_acked) begin seen[n_ack] = last_addr; n_ack++; end
            guard++;
        end
        chk("wrap_done", n_ack, 6);
        for (int k = 0; k < 6; k++) chk("wrap_addr", seen[k], exp_wrap[k]);
        chk("wrap_ip", ip, 16'hFFFE);
        step(0, 0, 0, 1, 3'd4, 0);
        chk("wrap_consume_ip", ip, 16'h0002);

        // Physical address wrap at FFFFFh
        step(1, 16'hFFFF, 16'h0012, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("phys_wrap_addr", bus_addr, 20'h00002);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            r_fl   = ($urandom_range(99) < 2);
            r_cs   = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
            r_ip   = ($urandom_range(3) == 0) ? 16'hFFF0 + 16'($urandom_range(15)) : 16'($urandom);
            r_cons = m_valid() && ($urandom_range(99) < 40);
            r_len  = 3'($urandom_range(6, 1));
            r_ack  = ($urandom_range(99) < 70);
            step(r_fl, r_cs, r_ip, r_cons, r_len, r_ack);
        end

        // Asynchronous reset in the middle of a request
        guard = 0;
        while (!(m_pend && prev_req) && guard < 20) begin
            step(0, 0, 0, m_valid(), 3'd6, 0);
            guard++;
        end
        chk("pre_reset_req", bus_req, 1'b1);
        flush = 0; consume = 0; bus_ack = 0;
        reset_n = 0;
        #1;
        model_reset();
        chk("arst_req", bus_req, 1'b0);
        chk("arst_valid", instr_valid, 1'b0);
        chk("arst_instr", instr, 48'h0);
        chk("arst_ip", ip, 16'h0);
        chk("arst_cs", cs, 16'h0);
        chk("arst_addr", bus_addr, 20'h0);
        chk("arst_segpref", segpref, 1'b0);
        chk("arst_segment", segment, 2'b00);
        @(posedge clock); #1;
        reset_n = 1;
        step(0, 0, 0, 0, 0, 0);
        chk("post_reset_req", bus_req, 1'b1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
